// File: rtl/id_pipe.sv
// MIPS instruction-decode stage: decodes one instruction per cycle, reads and forwards operands,
// resolves branches/jumps, detects load-use hazards and holds the decoded bundle for EX.
module id_pipe #(
    parameter int          NUM_FWD   = 2,
    parameter bit          DS_EN     = 1'b1,
    parameter logic [31:0] InitialPc = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             inst_i,
    input  logic [31:0]             pc_i,
    input  logic                    flush_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [32*NUM_FWD-1:0]   fwd_wdata_i,
    input  logic                    ex_is_load_i,
    output logic                    reg1_read_o,
    output logic                    reg2_read_o,
    output logic [4:0]              reg1_addr_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [31:0]             reg1_data_i,
    input  logic [31:0]             reg2_data_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              aluop_o,
    output logic [2:0]              alusel_o,
    output logic [31:0]             reg1_o,
    output logic [31:0]             reg2_o,
    output logic [4:0]              wd_o,
    output logic                    wreg_o,
    output logic [31:0]             inst_o,
    output logic [31:0]             pc_o,
    output logic                    is_delay_slot_o,
    output logic                    invalid_inst_o,
    output logic                    branch_flag_o,
    output logic [31:0]             branch_target_o,
    output logic                    stall_o
);

    localparam logic [7:0] ALU_OP_NOP  = 8'h00;
    localparam logic [7:0] ALU_OP_AND  = 8'h24;
    localparam logic [7:0] ALU_OP_OR   = 8'h25;
    localparam logic [7:0] ALU_OP_XOR  = 8'h26;
    localparam logic [7:0] ALU_OP_SLT  = 8'h2A;
    localparam logic [7:0] ALU_OP_ADDU = 8'h21;
    localparam logic [7:0] ALU_OP_SUBU = 8'h23;
    localparam logic [7:0] ALU_OP_SLL  = 8'h7C;
    localparam logic [7:0] ALU_OP_SRL  = 8'h02;
    localparam logic [7:0] ALU_OP_LW   = 8'hE3;
    localparam logic [7:0] ALU_OP_SW   = 8'hEB;
    localparam logic [7:0] ALU_OP_J    = 8'h4F;
    localparam logic [7:0] ALU_OP_JAL  = 8'h50;
    localparam logic [7:0] ALU_OP_BEQ  = 8'h51;
    localparam logic [7:0] ALU_OP_BNE  = 8'h52;

    localparam logic [2:0] ALU_RES_NOP         = 3'd0;
    localparam logic [2:0] ALU_RES_LOGIC       = 3'd1;
    localparam logic [2:0] ALU_RES_SHIFT       = 3'd2;
    localparam logic [2:0] ALU_RES_ARITH       = 3'd4;
    localparam logic [2:0] ALU_RES_JUMP_BRANCH = 3'd6;
    localparam logic [2:0] ALU_RES_LOAD_STORE  = 3'd7;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_ds;
        logic        invalid;
    } bundle_t;

    // Packed per-source views of the flattened forwarding buses.
    logic [NUM_FWD-1:0][4:0]  fwd_wd;
    logic [NUM_FWD-1:0][31:0] fwd_wdata;
    assign fwd_wd    = fwd_wd_i;
    assign fwd_wdata = fwd_wdata_i;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign sa     = inst_i[10:6];
    assign funct  = inst_i[5:0];
    assign imm16  = inst_i[15:0];

    logic [31:0] pc_plus4, pc_plus8;
    assign pc_plus4 = pc_i + 32'd4;
    assign pc_plus8 = pc_i + 32'd8;

    // Decode
    logic        r1_rd, r2_rd;
    logic [31:0] imm;
    logic [7:0]  dec_aluop;
    logic [2:0]  dec_alusel;
    logic [4:0]  dec_wd;
    logic        dec_wreg, dec_invalid;
    logic        is_beq, is_bne, is_j, is_jal, is_shift;

    always_comb begin
        r1_rd       = 1'b0;
        r2_rd       = 1'b0;
        imm         = 32'h0;
        dec_aluop   = ALU_OP_NOP;
        dec_alusel  = ALU_RES_NOP;
        dec_wd      = 5'd0;
        dec_wreg    = 1'b0;
        dec_invalid = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_j        = 1'b0;
        is_jal      = 1'b0;
        is_shift    = 1'b0;
        unique case (opcode)
            OP_SPECIAL: begin
                r1_rd      = 1'b1;
                r2_rd      = 1'b1;
                dec_wd     = rd;
                dec_wreg   = 1'b1;
                dec_alusel = ALU_RES_LOGIC;
                unique case (funct)
                    FN_AND:  dec_aluop = ALU_OP_AND;
                    FN_OR:   dec_aluop = ALU_OP_OR;
                    FN_XOR:  dec_aluop = ALU_OP_XOR;
                    FN_ADDU: begin dec_aluop = ALU_OP_ADDU; dec_alusel = ALU_RES_ARITH; end
                    FN_SUBU: begin dec_aluop = ALU_OP_SUBU; dec_alusel = ALU_RES_ARITH; end
                    FN_SLT:  begin dec_aluop = ALU_OP_SLT;  dec_alusel = ALU_RES_ARITH; end
                    FN_SLL, FN_SRL: begin
                        // Shift amount comes from sa, so rs is never read.
                        dec_aluop  = (funct == FN_SLL) ? ALU_OP_SLL : ALU_OP_SRL;
                        dec_alusel = ALU_RES_SHIFT;
                        r1_rd      = 1'b0;
                        is_shift   = 1'b1;
                    end
                    default: begin
                        r1_rd       = 1'b0;
                        r2_rd       = 1'b0;
                        dec_wd      = 5'd0;
                        dec_wreg    = 1'b0;
                        dec_alusel  = ALU_RES_NOP;
                        dec_invalid = 1'b1;
                    end
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                r1_rd      = 1'b1;
                imm        = {16'h0, imm16};
                dec_wd     = rt;
                dec_wreg   = 1'b1;
                dec_alusel = ALU_RES_LOGIC;
                dec_aluop  = (opcode == OP_ORI)  ? ALU_OP_OR :
                             (opcode == OP_ANDI) ? ALU_OP_AND : ALU_OP_XOR;
            end
            OP_LUI: begin
                imm        = {imm16, 16'h0};
                dec_wd     = rt;
                dec_wreg   = 1'b1;
                dec_aluop  = ALU_OP_OR;
                dec_alusel = ALU_RES_LOGIC;
            end
            OP_ADDIU, OP_SLTI: begin
                r1_rd      = 1'b1;
                imm        = {{16{imm16[15]}}, imm16};
                dec_wd     = rt;
                dec_wreg   = 1'b1;
                dec_alusel = ALU_RES_ARITH;
                dec_aluop  = (opcode == OP_ADDIU) ? ALU_OP_ADDU : ALU_OP_SLT;
            end
            OP_LW: begin
                r1_rd      = 1'b1;
                imm        = {{16{imm16[15]}}, imm16};
                dec_wd     = rt;
                dec_wreg   = 1'b1;
                dec_aluop  = ALU_OP_LW;
                dec_alusel = ALU_RES_LOAD_STORE;
            end
            OP_SW: begin
                // reg2 carries store data; the offset travels in inst_o.
                r1_rd      = 1'b1;
                r2_rd      = 1'b1;
                imm        = {{16{imm16[15]}}, imm16};
                dec_aluop  = ALU_OP_SW;
                dec_alusel = ALU_RES_LOAD_STORE;
            end
            OP_BEQ, OP_BNE: begin
                r1_rd      = 1'b1;
                r2_rd      = 1'b1;
                imm        = {{16{imm16[15]}}, imm16};
                is_beq     = (opcode == OP_BEQ);
                is_bne     = (opcode == OP_BNE);
                dec_aluop  = is_beq ? ALU_OP_BEQ : ALU_OP_BNE;
                dec_alusel = ALU_RES_JUMP_BRANCH;
            end
            OP_J: begin
                is_j       = 1'b1;
                dec_aluop  = ALU_OP_J;
                dec_alusel = ALU_RES_JUMP_BRANCH;
            end
            OP_JAL: begin
                is_jal     = 1'b1;
                dec_wd     = 5'd31;
                dec_wreg   = 1'b1;
                dec_aluop  = ALU_OP_JAL;
                dec_alusel = ALU_RES_JUMP_BRANCH;
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    assign reg1_read_o = r1_rd;
    assign reg2_read_o = r2_rd;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    // Per-source address match; r0 never matches.
    logic [NUM_FWD-1:0] hit1, hit2;
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
        assign hit1[k] = fwd_wreg_i[k] && (fwd_wd[k] == rs) && (rs != 5'd0);
        assign hit2[k] = fwd_wreg_i[k] && (fwd_wd[k] == rt) && (rt != 5'd0);
    end

    // Walk oldest to youngest so the youngest (lowest index) match wins.
    logic [31:0] opnd1, opnd2;
    always_comb begin
        opnd1 = (rs == 5'd0) ? 32'h0 : reg1_data_i;
        opnd2 = (rt == 5'd0) ? 32'h0 : reg2_data_i;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (hit1[k]) opnd1 = fwd_wdata[k];
            if (hit2[k]) opnd2 = fwd_wdata[k];
        end
    end

    logic [31:0] dec_reg1, dec_reg2;
    always_comb begin
        dec_reg1 = r1_rd ? opnd1 : 32'h0;
        if (is_jal)   dec_reg1 = pc_plus8;
        if (is_shift) dec_reg1 = {27'h0, sa};
        dec_reg2 = r2_rd ? opnd2 : imm;
    end

    logic is_cti, taken, hazard, accept;
    assign is_cti = is_beq | is_bne | is_j | is_jal;
    assign taken  = (is_beq & (opnd1 == opnd2)) | (is_bne & (opnd1 != opnd2)) | is_j | is_jal;

    assign hazard = in_valid & ex_is_load_i & fwd_wreg_i[0] & (fwd_wd[0] != 5'd0) &
                    ((r1_rd & (fwd_wd[0] == rs)) | (r2_rd & (fwd_wd[0] == rt)));

    logic out_valid_q, out_valid_d;
    logic ds_pending_q, ds_pending_d;
    bundle_t bundle_q, bundle_d, dec_bundle, reset_bundle;

    assign in_ready = !rst & !flush_i & !hazard & (!out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign stall_o  = hazard;

    assign branch_flag_o   = accept & taken;
    assign branch_target_o = (is_j | is_jal) ? {pc_plus4[31:28], inst_i[25:0], 2'b00}
                                             : pc_plus4 + {imm[29:0], 2'b00};

    always_comb begin
        dec_bundle         = '0;
        dec_bundle.aluop   = dec_aluop;
        dec_bundle.alusel  = dec_alusel;
        dec_bundle.reg1    = dec_reg1;
        dec_bundle.reg2    = dec_reg2;
        dec_bundle.wd      = dec_wd;
        dec_bundle.wreg    = dec_wreg;
        dec_bundle.inst    = inst_i;
        dec_bundle.pc      = pc_i;
        dec_bundle.is_ds   = DS_EN & ds_pending_q;
        dec_bundle.invalid = dec_invalid;
        reset_bundle       = '0;
        reset_bundle.pc    = InitialPc;
    end

    // Flush wins over accept and hold; reset is applied in the register itself.
    always_comb begin
        out_valid_d  = out_valid_q;
        ds_pending_d = ds_pending_q;
        bundle_d     = bundle_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            ds_pending_d = 1'b0;
        end else if (accept) begin
            bundle_d     = dec_bundle;
            out_valid_d  = 1'b1;
            ds_pending_d = DS_EN & is_cti;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            ds_pending_q <= 1'b0;
            bundle_q     <= reset_bundle;
        end else begin
            out_valid_q  <= out_valid_d;
            ds_pending_q <= ds_pending_d;
            bundle_q     <= bundle_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign aluop_o         = bundle_q.aluop;
    assign alusel_o        = bundle_q.alusel;
    assign reg1_o          = bundle_q.reg1;
    assign reg2_o          = bundle_q.reg2;
    assign wd_o            = bundle_q.wd;
    assign wreg_o          = bundle_q.wreg;
    assign inst_o          = bundle_q.inst;
    assign pc_o            = bundle_q.pc;
    assign is_delay_slot_o = bundle_q.is_ds;
    assign invalid_inst_o  = bundle_q.invalid;

endmodule
